// File: rtl/hasti_master_arbiter_pkg.sv
// Shared definitions for the two-master AHB-Lite (hasti) arbiter:
// transfer types, bus-owner encoding and the fixed/reset bus field values.
package hasti_master_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'h0;
  localparam logic [1:0] HTRANS_BUSY   = 2'h1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'h2;
  localparam logic [1:0] HTRANS_SEQ    = 2'h3;

  localparam logic [2:0] HBURST_SINGLE = 3'h0;
  localparam logic       HMASTLOCK_OFF = 1'b0;

  localparam logic [2:0] RESET_HSIZE = 3'h2;
  localparam logic [3:0] RESET_HPROT = 4'h3;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_M0   = 2'd1,
    OWNER_M1   = 2'd2
  } owner_e;

  // BUSY and IDLE never start a transfer; SEQ is treated like NONSEQ.
  function automatic logic is_active(input logic [1:0] htrans);
    return !((htrans == HTRANS_IDLE) || (htrans == HTRANS_BUSY));
  endfunction

endpackage

// File: rtl/hasti_master_hold.sv
// Per-master front end: holds an address phase that could not be issued,
// selects live vs held request, and generates the master's hready/hresp.
module hasti_master_hold
  import hasti_master_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] m_haddr,
  input  logic                  m_hwrite,
  input  logic [2:0]            m_hsize,
  input  logic [3:0]            m_hprot,
  input  logic [1:0]            m_htrans,
  output logic                  m_hready,
  output logic                  m_hresp,
  input  logic                  bus_hready,
  input  logic                  bus_hresp,
  input  logic                  dp_own,
  input  logic                  clear,
  output logic                  req,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_write,
  output logic [2:0]            req_size,
  output logic [3:0]            req_prot
);

  logic                  pend_valid_q, pend_valid_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic                  pend_write_q, pend_write_d;
  logic [2:0]            pend_size_q, pend_size_d;
  logic [3:0]            pend_prot_q, pend_prot_d;
  logic                  live;

  always_comb begin
    m_hready  = pend_valid_q ? 1'b0 : (dp_own ? bus_hready : 1'b1);
    m_hresp   = dp_own & bus_hresp;
    live      = is_active(m_htrans) & m_hready;
    req       = pend_valid_q | live;
    req_addr  = pend_valid_q ? pend_addr_q  : m_haddr;
    req_write = pend_valid_q ? pend_write_q : m_hwrite;
    req_size  = pend_valid_q ? pend_size_q  : m_hsize;
    req_prot  = pend_valid_q ? pend_prot_q  : m_hprot;

    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_write_d = pend_write_q;
    pend_size_d  = pend_size_q;
    pend_prot_d  = pend_prot_q;
    // A live request that is not accepted this cycle (lost or stalled) is parked here.
    if (clear) begin
      pend_valid_d = 1'b0;
    end else if (live) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = m_haddr;
      pend_write_d = m_hwrite;
      pend_size_d  = m_hsize;
      pend_prot_d  = m_hprot;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_write_q <= 1'b0;
      pend_size_q  <= 3'h0;
      pend_prot_q  <= 4'h0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_write_q <= pend_write_d;
      pend_size_q  <= pend_size_d;
      pend_prot_q  <= pend_prot_d;
    end
  end

endmodule

// File: rtl/hasti_master_arbiter.sv
// Two-master to one-slave AHB-Lite arbiter: arbitrates the shared address
// phase, keeps a stalled address stable, and routes the data phase by owner.
module hasti_master_arbiter
  import hasti_master_arbiter_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b0,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] io_m0_haddr,
  input  logic                  io_m0_hwrite,
  input  logic [2:0]            io_m0_hsize,
  input  logic [3:0]            io_m0_hprot,
  input  logic [1:0]            io_m0_htrans,
  input  logic [DATA_WIDTH-1:0] io_m0_hwdata,
  output logic [DATA_WIDTH-1:0] io_m0_hrdata,
  output logic                  io_m0_hready,
  output logic                  io_m0_hresp,
  input  logic [ADDR_WIDTH-1:0] io_m1_haddr,
  input  logic                  io_m1_hwrite,
  input  logic [2:0]            io_m1_hsize,
  input  logic [3:0]            io_m1_hprot,
  input  logic [1:0]            io_m1_htrans,
  input  logic [DATA_WIDTH-1:0] io_m1_hwdata,
  output logic [DATA_WIDTH-1:0] io_m1_hrdata,
  output logic                  io_m1_hready,
  output logic                  io_m1_hresp,
  output logic [ADDR_WIDTH-1:0] io_bus_haddr,
  output logic                  io_bus_hwrite,
  output logic [2:0]            io_bus_hsize,
  output logic [2:0]            io_bus_hburst,
  output logic [3:0]            io_bus_hprot,
  output logic [1:0]            io_bus_htrans,
  output logic                  io_bus_hmastlock,
  output logic [DATA_WIDTH-1:0] io_bus_hwdata,
  input  logic [DATA_WIDTH-1:0] io_bus_hrdata,
  input  logic                  io_bus_hready,
  input  logic                  io_bus_hresp
);

  logic                  req_0, req_1;
  logic [ADDR_WIDTH-1:0] src_addr_0, src_addr_1;
  logic                  src_write_0, src_write_1;
  logic [2:0]            src_size_0, src_size_1;
  logic [3:0]            src_prot_0, src_prot_1;
  logic                  clear_0, clear_1;

  owner_e                winner;
  owner_e                dp_owner_q, dp_owner_d;
  owner_e                last_grant_q, last_grant_d;
  owner_e                hold_owner_q, hold_owner_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [ADDR_WIDTH-1:0] last_addr_q;
  logic                  last_write_q;
  logic [2:0]            last_size_q;
  logic [3:0]            last_prot_q;

  assign clear_0 = io_bus_hready && (winner == OWNER_M0);
  assign clear_1 = io_bus_hready && (winner == OWNER_M1);

  hasti_master_hold #(.ADDR_WIDTH(ADDR_WIDTH)) u_hold_m0 (
    .clk        (clk),
    .reset      (reset),
    .m_haddr    (io_m0_haddr),
    .m_hwrite   (io_m0_hwrite),
    .m_hsize    (io_m0_hsize),
    .m_hprot    (io_m0_hprot),
    .m_htrans   (io_m0_htrans),
    .m_hready   (io_m0_hready),
    .m_hresp    (io_m0_hresp),
    .bus_hready (io_bus_hready),
    .bus_hresp  (io_bus_hresp),
    .dp_own     (dp_owner_q == OWNER_M0),
    .clear      (clear_0),
    .req        (req_0),
    .req_addr   (src_addr_0),
    .req_write  (src_write_0),
    .req_size   (src_size_0),
    .req_prot   (src_prot_0)
  );

  hasti_master_hold #(.ADDR_WIDTH(ADDR_WIDTH)) u_hold_m1 (
    .clk        (clk),
    .reset      (reset),
    .m_haddr    (io_m1_haddr),
    .m_hwrite   (io_m1_hwrite),
    .m_hsize    (io_m1_hsize),
    .m_hprot    (io_m1_hprot),
    .m_htrans   (io_m1_htrans),
    .m_hready   (io_m1_hready),
    .m_hresp    (io_m1_hresp),
    .bus_hready (io_bus_hready),
    .bus_hresp  (io_bus_hresp),
    .dp_own     (dp_owner_q == OWNER_M1),
    .clear      (clear_1),
    .req        (req_1),
    .req_addr   (src_addr_1),
    .req_write  (src_write_1),
    .req_size   (src_size_1),
    .req_prot   (src_prot_1)
  );

  // A stalled address phase keeps its owner until the slave accepts it.
  always_comb begin
    winner = OWNER_NONE;
    if (hold_valid_q) begin
      winner = hold_owner_q;
    end else if (req_0 && req_1) begin
      winner = (ROUND_ROBIN && (last_grant_q == OWNER_M0)) ? OWNER_M1 : OWNER_M0;
    end else if (req_0) begin
      winner = OWNER_M0;
    end else if (req_1) begin
      winner = OWNER_M1;
    end
  end

  always_comb begin
    io_bus_haddr  = last_addr_q;
    io_bus_hwrite = last_write_q;
    io_bus_hsize  = last_size_q;
    io_bus_hprot  = last_prot_q;
    io_bus_htrans = HTRANS_IDLE;
    case (winner)
      OWNER_M0: begin
        io_bus_haddr  = src_addr_0;
        io_bus_hwrite = src_write_0;
        io_bus_hsize  = src_size_0;
        io_bus_hprot  = src_prot_0;
        io_bus_htrans = HTRANS_NONSEQ;
      end
      OWNER_M1: begin
        io_bus_haddr  = src_addr_1;
        io_bus_hwrite = src_write_1;
        io_bus_hsize  = src_size_1;
        io_bus_hprot  = src_prot_1;
        io_bus_htrans = HTRANS_NONSEQ;
      end
      default: ;
    endcase
  end

  assign io_bus_hburst    = HBURST_SINGLE;
  assign io_bus_hmastlock = HMASTLOCK_OFF;
  assign io_m0_hrdata     = io_bus_hrdata;
  assign io_m1_hrdata     = io_bus_hrdata;

  always_comb begin
    case (dp_owner_q)
      OWNER_M0: io_bus_hwdata = io_m0_hwdata;
      OWNER_M1: io_bus_hwdata = io_m1_hwdata;
      default:  io_bus_hwdata = '0;
    endcase
  end

  always_comb begin
    dp_owner_d   = dp_owner_q;
    last_grant_d = last_grant_q;
    hold_valid_d = hold_valid_q;
    hold_owner_d = hold_owner_q;
    if (io_bus_hready) begin
      dp_owner_d   = winner;
      hold_valid_d = 1'b0;
      if (winner != OWNER_NONE) begin
        last_grant_d = winner;
      end
    end else if (winner != OWNER_NONE) begin
      hold_valid_d = 1'b1;
      hold_owner_d = winner;
    end
  end

  // The idle bus repeats whatever address fields were last driven.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dp_owner_q   <= OWNER_NONE;
      last_grant_q <= OWNER_M1;
      hold_valid_q <= 1'b0;
      hold_owner_q <= OWNER_NONE;
      last_addr_q  <= '0;
      last_write_q <= 1'b0;
      last_size_q  <= RESET_HSIZE;
      last_prot_q  <= RESET_HPROT;
    end else begin
      dp_owner_q   <= dp_owner_d;
      last_grant_q <= last_grant_d;
      hold_valid_q <= hold_valid_d;
      hold_owner_q <= hold_owner_d;
      last_addr_q  <= io_bus_haddr;
      last_write_q <= io_bus_hwrite;
      last_size_q  <= io_bus_hsize;
      last_prot_q  <= io_bus_hprot;
    end
  end

endmodule

// File: tb/tb_hasti_master_arbiter.sv
// Bench for hasti_master_arbiter: a fixed-priority and a round-robin instance
// share stimulus and are compared every cycle against a transaction-level model.
module tb_hasti_master_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          write;
    logic [2:0]    size;
    logic [3:0]    prot;
  } tx_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] m_haddr  [2];
  logic          m_hwrite [2];
  logic [2:0]    m_hsize  [2];
  logic [3:0]    m_hprot  [2];
  logic [1:0]    m_htrans [2];
  logic [DW-1:0] m_hwdata [2];
  logic [DW-1:0] bus_hrdata;
  logic          bus_hready;
  logic          bus_hresp;

  logic [DW-1:0] o_hrdata [2][2];
  logic          o_hready [2][2];
  logic          o_hresp  [2][2];
  logic [AW-1:0] b_haddr     [2];
  logic          b_hwrite    [2];
  logic [2:0]    b_hsize     [2];
  logic [2:0]    b_hburst    [2];
  logic [3:0]    b_hprot     [2];
  logic [1:0]    b_htrans    [2];
  logic          b_hmastlock [2];
  logic [DW-1:0] b_hwdata    [2];

  // Instance 0 is fixed priority, instance 1 is round robin.
  for (genvar k = 0; k < 2; k++) begin : g_dut
    hasti_master_arbiter #(.ROUND_ROBIN(k == 1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
      .clk              (clk),
      .reset            (reset),
      .io_m0_haddr      (m_haddr[0]),
      .io_m0_hwrite     (m_hwrite[0]),
      .io_m0_hsize      (m_hsize[0]),
      .io_m0_hprot      (m_hprot[0]),
      .io_m0_htrans     (m_htrans[0]),
      .io_m0_hwdata     (m_hwdata[0]),
      .io_m0_hrdata     (o_hrdata[k][0]),
      .io_m0_hready     (o_hready[k][0]),
      .io_m0_hresp      (o_hresp[k][0]),
      .io_m1_haddr      (m_haddr[1]),
      .io_m1_hwrite     (m_hwrite[1]),
      .io_m1_hsize      (m_hsize[1]),
      .io_m1_hprot      (m_hprot[1]),
      .io_m1_htrans     (m_htrans[1]),
      .io_m1_hwdata     (m_hwdata[1]),
      .io_m1_hrdata     (o_hrdata[k][1]),
      .io_m1_hready     (o_hready[k][1]),
      .io_m1_hresp      (o_hresp[k][1]),
      .io_bus_haddr     (b_haddr[k]),
      .io_bus_hwrite    (b_hwrite[k]),
      .io_bus_hsize     (b_hsize[k]),
      .io_bus_hburst    (b_hburst[k]),
      .io_bus_hprot     (b_hprot[k]),
      .io_bus_htrans    (b_htrans[k]),
      .io_bus_hmastlock (b_hmastlock[k]),
      .io_bus_hwdata    (b_hwdata[k]),
      .io_bus_hrdata    (bus_hrdata),
      .io_bus_hready    (bus_hready),
      .io_bus_hresp     (bus_hresp)
    );
  end

  // Reference model: per master at most one parked transfer, plus which
  // master is stuck on a stalled bus, who owns the data phase, who won last.
  bit  pend_valid [2][2];
  tx_t pend_tx    [2][2];
  int  stuck      [2];
  int  dp_owner   [2];
  int  last_grant [2];
  tx_t last_tx    [2];

  logic          exp_hready [2][2];
  logic          exp_hresp  [2][2];
  logic [AW+9:0] exp_bus    [2];
  logic [DW-1:0] exp_hwdata [2];
  int            winner     [2];
  bit            live       [2][2];
  tx_t           src        [2][2];

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      pend_valid[k][0] = 1'b0;
      pend_valid[k][1] = 1'b0;
      stuck[k]         = -1;
      dp_owner[k]      = -1;
      last_grant[k]    = 1;
      last_tx[k]       = {{AW{1'b0}}, 1'b0, 3'h2, 4'h3};
    end
  endtask

  task automatic modelEval(input int k);
    bit req [2];
    for (int n = 0; n < 2; n++) begin
      exp_hready[k][n] = pend_valid[k][n] ? 1'b0 : ((dp_owner[k] == n) ? bus_hready : 1'b1);
      exp_hresp[k][n]  = (dp_owner[k] == n) ? bus_hresp : 1'b0;
      live[k][n]       = m_htrans[n][1] && exp_hready[k][n];
      src[k][n]        = pend_valid[k][n] ? pend_tx[k][n]
                                          : {m_haddr[n], m_hwrite[n], m_hsize[n], m_hprot[n]};
      req[n]           = pend_valid[k][n] || live[k][n];
    end
    if (stuck[k] >= 0)          winner[k] = stuck[k];
    else if (req[0] && req[1])  winner[k] = (k == 1) ? 1 - last_grant[k] : 0;
    else if (req[0])            winner[k] = 0;
    else if (req[1])            winner[k] = 1;
    else                        winner[k] = -1;
    if (winner[k] >= 0) exp_bus[k] = {src[k][winner[k]], 2'b10};
    else                exp_bus[k] = {last_tx[k], 2'b00};
    if (dp_owner[k] == 0)      exp_hwdata[k] = m_hwdata[0];
    else if (dp_owner[k] == 1) exp_hwdata[k] = m_hwdata[1];
    else                       exp_hwdata[k] = '0;
  endtask

  task automatic modelStep(input int k);
    if (winner[k] >= 0) last_tx[k] = src[k][winner[k]];
    if (bus_hready) begin
      dp_owner[k] = winner[k];
      stuck[k]    = -1;
      if (winner[k] >= 0) begin
        last_grant[k] = winner[k];
        pend_valid[k][winner[k]] = 1'b0;
      end
    end else if (winner[k] >= 0) begin
      stuck[k] = winner[k];
    end
    for (int n = 0; n < 2; n++) begin
      if (live[k][n] && !(bus_hready && winner[k] == n)) begin
        pend_valid[k][n] = 1'b1;
        pend_tx[k][n]    = src[k][n];
      end
    end
  endtask

  task automatic checkAll();
    for (int k = 0; k < 2; k++) begin
      modelEval(k);
      checkOutput($sformatf("dut%0d bus addr phase", k),
                  64'({b_haddr[k], b_hwrite[k], b_hsize[k], b_hprot[k], b_htrans[k]}), 64'(exp_bus[k]));
      checkOutput($sformatf("dut%0d bus hwdata", k), 64'(b_hwdata[k]), 64'(exp_hwdata[k]));
      checkOutput($sformatf("dut%0d hburst", k), 64'(b_hburst[k]), 64'(0));
      checkOutput($sformatf("dut%0d hmastlock", k), 64'(b_hmastlock[k]), 64'(0));
      for (int n = 0; n < 2; n++) begin
        checkOutput($sformatf("dut%0d m%0d hready", k, n), 64'(o_hready[k][n]), 64'(exp_hready[k][n]));
        checkOutput($sformatf("dut%0d m%0d hresp", k, n), 64'(o_hresp[k][n]), 64'(exp_hresp[k][n]));
        checkOutput($sformatf("dut%0d m%0d hrdata", k, n), 64'(o_hrdata[k][n]), 64'(bus_hrdata));
      end
    end
  endtask

  // Drives one cycle's inputs just after the falling edge and checks outputs.
  task automatic applyStimulus(input logic [1:0] t0, input logic [AW-1:0] a0, input logic w0,
                               input logic [DW-1:0] d0, input logic [1:0] t1, input logic [AW-1:0] a1,
                               input logic w1, input logic [DW-1:0] d1, input logic rdy,
                               input logic resp, input logic [DW-1:0] rdata);
    m_htrans[0] = t0; m_haddr[0] = a0; m_hwrite[0] = w0; m_hwdata[0] = d0;
    m_htrans[1] = t1; m_haddr[1] = a1; m_hwrite[1] = w1; m_hwdata[1] = d1;
    bus_hready = rdy; bus_hresp = resp; bus_hrdata = rdata;
    #1;
    checkAll();
  endtask

  task automatic advance();
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    @(negedge clk);
  endtask

  task automatic idleCycle(input logic rdy, input logic resp, input logic [DW-1:0] rdata);
    applyStimulus(2'h0, '0, 1'b0, '0, 2'h0, '0, 1'b0, '0, rdy, resp, rdata);
  endtask

  task automatic checkResetValues(input string tag);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("%s dut%0d htrans", tag, k), 64'(b_htrans[k]), 64'(0));
      checkOutput($sformatf("%s dut%0d haddr", tag, k), 64'(b_haddr[k]), 64'(0));
      checkOutput($sformatf("%s dut%0d hsize/hprot", tag, k), 64'({b_hsize[k], b_hprot[k]}), 64'(7'h23));
      checkOutput($sformatf("%s dut%0d m1 hready", tag, k), 64'(o_hready[k][1]), 64'(1));
    end
  endtask

  initial begin
    for (int n = 0; n < 2; n++) begin
      m_haddr[n] = '0; m_hwrite[n] = 1'b0; m_hsize[n] = 3'h2; m_hprot[n] = 4'h3;
      m_htrans[n] = 2'h0; m_hwdata[n] = '0;
    end
    bus_hready = 1'b1; bus_hresp = 1'b0; bus_hrdata = '0;
    reset = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkAll();
    checkResetValues("reset");
    reset = 1'b1;

    // Both masters request every cycle on the round-robin instance.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'h2, AW'(32'h100 + i), 1'b0, '0, 2'h2, AW'(32'h200 + i), 1'b0, '0, 1'b1, 1'b0, '0);
      checkOutput($sformatf("rr grant %0d", i), 64'(b_haddr[1][11:8]), 64'((i % 2 == 0) ? 1 : 2));
      advance();
    end
    repeat (4) begin idleCycle(1'b1, 1'b0, '0); advance(); end

    // Single uncontended write from m0.
    applyStimulus(2'h2, 32'h1000, 1'b1, '0, 2'h0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
    checkOutput("write addr", 64'({b_haddr[0], b_htrans[0]}), 64'({32'h1000, 2'h2}));
    checkOutput("write m0 hready a", 64'(o_hready[0][0]), 64'(1));
    advance();
    applyStimulus(2'h0, '0, 1'b0, 32'hDEADBEEF, 2'h0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
    checkOutput("write hwdata", 64'(b_hwdata[0]), 64'(32'hDEADBEEF));
    checkOutput("write m0 hready d", 64'(o_hready[0][0]), 64'(1));
    advance();

    // Same-cycle conflict on the fixed-priority instance.
    applyStimulus(2'h2, 32'h10, 1'b0, '0, 2'h2, 32'h20, 1'b0, '0, 1'b1, 1'b0, '0);
    checkOutput("conflict t addr", 64'(b_haddr[0]), 64'(32'h10));
    advance();
    idleCycle(1'b1, 1'b0, 32'h1111_0010);
    checkOutput("conflict t+1 addr", 64'(b_haddr[0]), 64'(32'h20));
    checkOutput("conflict t+1 m1 hready", 64'(o_hready[0][1]), 64'(0));
    advance();
    idleCycle(1'b1, 1'b0, 32'hCAFE0020);
    checkOutput("conflict t+2 m1 hready", 64'(o_hready[0][1]), 64'(1));
    checkOutput("conflict t+2 m1 hrdata", 64'(o_hrdata[0][1]), 64'(32'hCAFE0020));
    advance();

    // Slave stalls m1's address phase; m0 parks behind it.
    applyStimulus(2'h0, '0, 1'b0, '0, 2'h2, 32'h300, 1'b1, '0, 1'b0, 1'b0, '0);
    checkOutput("wait addr 1", 64'({b_haddr[0], b_htrans[0]}), 64'({32'h300, 2'h2}));
    advance();
    applyStimulus(2'h2, 32'h400, 1'b0, '0, 2'h0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("wait addr 2", 64'({b_haddr[0], b_htrans[0]}), 64'({32'h300, 2'h2}));
    advance();
    idleCycle(1'b0, 1'b0, '0);
    checkOutput("wait addr 3", 64'({b_haddr[0], b_htrans[0]}), 64'({32'h300, 2'h2}));
    checkOutput("wait m0 hready", 64'(o_hready[0][0]), 64'(0));
    advance();
    idleCycle(1'b1, 1'b0, '0);
    advance();
    idleCycle(1'b1, 1'b0, '0);
    checkOutput("wait m0 issued", 64'({b_haddr[0], b_htrans[0]}), 64'({32'h400, 2'h2}));
    advance();
    idleCycle(1'b1, 1'b0, '0);
    advance();

    // Two-cycle ERROR response on m0's transfer.
    applyStimulus(2'h2, 32'h500, 1'b0, '0, 2'h0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
    advance();
    idleCycle(1'b0, 1'b1, '0);
    checkOutput("error c1 m0 hresp/hready", 64'({o_hresp[0][0], o_hready[0][0]}), 64'(2'b10));
    checkOutput("error c1 m1 hresp", 64'(o_hresp[0][1]), 64'(0));
    advance();
    idleCycle(1'b1, 1'b1, '0);
    checkOutput("error c2 m0 hresp/hready", 64'({o_hresp[0][0], o_hready[0][0]}), 64'(2'b11));
    checkOutput("error c2 m1 hresp", 64'(o_hresp[0][1]), 64'(0));
    advance();

    // Random traffic, mostly-ready slave with occasional error responses.
    repeat (400) begin
      m_hsize[0] = 3'($urandom_range(0, 7)); m_hprot[0] = 4'($urandom);
      m_hsize[1] = 3'($urandom_range(0, 7)); m_hprot[1] = 4'($urandom);
      applyStimulus(2'($urandom), AW'($urandom), 1'($urandom), DW'($urandom),
                    2'($urandom), AW'($urandom), 1'($urandom), DW'($urandom),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, DW'($urandom));
      advance();
    end
    m_hsize[0] = 3'h2; m_hprot[0] = 4'h3; m_hsize[1] = 3'h2; m_hprot[1] = 4'h3;
    repeat (6) begin idleCycle(1'b1, 1'b0, '0); advance(); end

    // Reset while m1 is parked behind m0.
    applyStimulus(2'h2, 32'h600, 1'b0, '0, 2'h2, 32'h700, 1'b0, '0, 1'b1, 1'b0, '0);
    advance();
    m_htrans[0] = 2'h0; m_htrans[1] = 2'h0;
    reset = 1'b0;
    #1;
    modelReset();
    checkAll();
    checkResetValues("midreset");
    @(negedge clk);
    reset = 1'b1;
    idleCycle(1'b1, 1'b0, '0);
    checkOutput("post reset dut0 htrans", 64'(b_htrans[0]), 64'(0));
    checkOutput("post reset dut1 htrans", 64'(b_htrans[1]), 64'(0));
    advance();
    idleCycle(1'b1, 1'b0, '0);
    advance();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
